multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore FSM that sequences the shared datapath (single ALU, unified instruction/data memory, IR, PC, register file) for a multicycle RV32I subset: lw, sw, R-type, I-type ALU, beq, jal.
- Drives datapath mux selects, write enables and the 2-bit ALUOp that feeds the existing funct-based ALU decoder.
- Sits beside that decoder in the Control Unit and replaces the single-cycle main decoder in the multicycle build.

Parameters:
- WAIT_MEM, 1, 1 = honour mem_ready in memory states; 0 = mem_ready ignored (treated as always 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- op  in  7  instruction opcode, IR[6:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = Result.
- mem_write  out  1  memory write enable.
- ir_write  out  1  IR and OldPC enable.
- result_src  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_src_a  out  2  A select: 00 = PC, 01 = OldPC, 10 = RD1.
- alu_src_b  out  2  B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct decode.
- reg_write  out  1  register file write enable.
- illegal_instr  out  1  one-cycle pulse on unsupported opcode.
- state  out  4  current state encoding, for debug.

Behaviour:
- Reset: async assert forces state = FETCH (0). While rst_n = 0, all enables (pc_write, mem_write, ir_write, reg_write, illegal_instr) are 0. Selects take FETCH values: adr_src 0, alu_src_a 00, alu_src_b 10, alu_op 00, result_src 10. Reset mid-instruction abandons it; no write completes after the assertion edge.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10. Codes 11–15 are unreachable and go to FETCH on the next edge.
- Outputs are combinational from state. Any output not listed for a state is 0.
- Define rdy = mem_ready | ~WAIT_MEM.

State outputs and transitions:
- FETCH: adr_src 0, alu_src_a 00, alu_src_b 10, alu_op 00, result_src 10, ir_write = rdy, pc_update = rdy. Goes to DECODE if rdy, else stays.
- DECODE: alu_src_a 01, alu_src_b 01, alu_op 00 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 -> BEQ.
  - 1101111 -> JAL.
  - Any other op -> FETCH, with illegal_instr = 1 for this cycle only.
- MEMADR: alu_src_a 10, alu_src_b 01, alu_op 00. Goes to MEMREAD if op = lw, else MEMWRITE.
- MEMREAD: adr_src 1, result_src 00. Goes to MEMWB if rdy, else stays.
- MEMWB: result_src 01, reg_write 1. Goes to FETCH.
- MEMWRITE: adr_src 1, result_src 00, mem_write 1, held until rdy. Goes to FETCH if rdy, else stays.
- EXECR: alu_src_a 10, alu_src_b 00, alu_op 10. Goes to ALUWB.
- EXECI: alu_src_a 10, alu_src_b 01, alu_op 10. Goes to ALUWB.
- ALUWB: result_src 00, reg_write 1. Goes to FETCH.
- BEQ: alu_src_a 10, alu_src_b 00, alu_op 01, result_src 00, branch 1. Goes to FETCH.
- JAL: alu_src_a 01, alu_src_b 10, alu_op 00, result_src 00, pc_update 1. Goes to ALUWB (rd = PC+4).

PC write and latency:
- pc_write = pc_update | (branch & zero).
- Cycle counts with mem_ready tied high:
  - lw: 5.
  - sw: 4.
  - R-type, I-type: 4.
  - jal: 4.
  - beq: 3.
  - illegal op: 2.
- Each mem_ready-low cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- All outputs are stable while waiting; mem_write and adr_src stay asserted for the whole wait.

Test Plan:
- Reset: assert rst_n = 0 mid-EXECR -> state = 0 immediately (async); reg_write = 0, pc_write = 0, alu_src_b = 10. Release -> FETCH issues ir_write = 1 on the first cycle with mem_ready = 1.
- lw, op = 0000011, mem_ready = 1 -> states 0,1,2,3,4,0. reg_write = 1 only in state 4 with result_src = 01. Total 5 cycles.
- sw, op = 0100011, mem_ready low for 2 cycles in MEMWRITE -> mem_write = 1 for 3 consecutive cycles with adr_src = 1, then FETCH. No reg_write anywhere.
- beq, op = 1100011, with zero = 1 and then with zero = 0 -> in state 9, pc_write = 1 for zero = 1 and pc_write = 0 for zero = 0. alu_op = 01 in both cases.
- jal, op = 1101111 -> states 0,1,10,8,0. In state 10: pc_write = 1, alu_src_a = 01, alu_src_b = 10. reg_write = 1 in state 8.
- Illegal op = 1111111 -> DECODE then FETCH; illegal_instr = 1 for exactly one cycle. WAIT_MEM = 0 with mem_ready = 0 -> FETCH never stalls.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences the shared ALU, unified memory, IR, PC and
// register file for lw, sw, R-type, I-type ALU, beq and jal.
module multicycle_controller #(
    parameter bit WAIT_MEM = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       illegal_instr,
    output logic [3:0] state
);

    // state    | meaning
    // FETCH    | read instruction at PC, PC <= PC+4
    // DECODE   | read registers, branch target into ALUOut
    // MEMADR   | compute load/store address
    // MEMREAD  | read data memory at ALUOut
    // MEMWB    | write loaded data to rd
    // MEMWRITE | write RD2 to memory at ALUOut
    // EXECR    | R-type ALU operation
    // EXECI    | I-type ALU operation
    // ALUWB    | write ALUOut to rd
    // BEQ      | compare, take branch on zero
    // JAL      | PC <= target, ALUOut <= OldPC+4

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t cur_state, nxt_state;
    logic   rdy;
    logic   pc_update, branch;
    logic   ir_en, mem_en, reg_en, illegal;

    assign rdy = mem_ready | (WAIT_MEM == 1'b0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur_state <= S_FETCH;
        else        cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state  = S_FETCH;
        adr_src    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_en      = 1'b0;
        mem_en     = 1'b0;
        reg_en     = 1'b0;
        illegal    = 1'b0;
        case (cur_state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_en      = rdy;
                pc_update  = rdy;
                nxt_state  = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_R:         nxt_state = S_EXECR;
                    OP_I:         nxt_state = S_EXECI;
                    OP_BEQ:       nxt_state = S_BEQ;
                    OP_JAL:       nxt_state = S_JAL;
                    default: begin
                        nxt_state = S_FETCH;
                        illegal   = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                nxt_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src   = 1'b1;
                nxt_state = rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_en     = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_en    = 1'b1;
                nxt_state = rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                nxt_state = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                nxt_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_en = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                nxt_state = S_ALUWB;
            end
            default: nxt_state = S_FETCH;
        endcase
    end

    // Enables are gated by rst_n so nothing commits while reset is held.
    assign pc_write      = rst_n & (pc_update | (branch & zero));
    assign ir_write      = rst_n & ir_en;
    assign mem_write     = rst_n & mem_en;
    assign reg_write     = rst_n & reg_en;
    assign illegal_instr = rst_n & illegal;
    assign state         = cur_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: instruction table, hand-written
// stall/reset sequences, and randomized traffic against a path-based reference model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'b0110011;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [3:0] state;

    logic [6:0] op0 = 7'b0110011;
    logic       mem_ready0 = 1'b0;
    logic       pc_write0, adr_src0, mem_write0, ir_write0, reg_write0, illegal_instr0;
    logic [1:0] result_src0, alu_src_a0, alu_src_b0, alu_op0;
    logic [3:0] state0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.WAIT_MEM(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .illegal_instr(illegal_instr), .state(state)
    );

    multicycle_controller #(.WAIT_MEM(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .op(op0), .zero(zero), .mem_ready(mem_ready0),
        .pc_write(pc_write0), .adr_src(adr_src0), .mem_write(mem_write0), .ir_write(ir_write0),
        .result_src(result_src0), .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0),
        .alu_op(alu_op0), .reg_write(reg_write0), .illegal_instr(illegal_instr0), .state(state0)
    );

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       illegal_instr;
    } outs_t;

    typedef struct {
        logic [6:0] opc;
        logic       z;
        int         cycles;
        int         regw;
        int         memw;
        int         pcw;
        int         ill;
    } vec_t;

    typedef int path_t[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] o);
        return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    endfunction

    // Sequence of state codes each instruction class walks through, from the spec's latency table.
    function automatic path_t path_of(input logic [6:0] o);
        path_t p;
        case (o)
            7'b0000011: p = '{0, 1, 2, 3, 4};
            7'b0100011: p = '{0, 1, 2, 5};
            7'b0110011: p = '{0, 1, 6, 8};
            7'b0010011: p = '{0, 1, 7, 8};
            7'b1100011: p = '{0, 1, 9};
            7'b1101111: p = '{0, 1, 10, 8};
            default:    p = '{0, 1};
        endcase
        return p;
    endfunction

    function automatic outs_t expect_outs(input int code, input logic z, input logic rdy,
                                          input logic [6:0] o);
        outs_t e = '0;
        case (code)
            0:  begin e.alu_src_b = 2'b10; e.result_src = 2'b10; e.ir_write = rdy; e.pc_write = rdy; end
            1:  begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; e.illegal_instr = !is_legal(o); end
            2:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
            3:  e.adr_src = 1'b1;
            4:  begin e.result_src = 2'b01; e.reg_write = 1'b1; end
            5:  begin e.adr_src = 1'b1; e.mem_write = 1'b1; end
            6:  begin e.alu_src_a = 2'b10; e.alu_op = 2'b10; end
            7:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_op = 2'b10; end
            8:  e.reg_write = 1'b1;
            9:  begin e.alu_src_a = 2'b10; e.alu_op = 2'b01; e.pc_write = z; end
            10: begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic outs_t actual_outs();
        outs_t a;
        a.pc_write = pc_write; a.adr_src = adr_src; a.mem_write = mem_write;
        a.ir_write = ir_write; a.result_src = result_src; a.alu_src_a = alu_src_a;
        a.alu_src_b = alu_src_b; a.alu_op = alu_op; a.reg_write = reg_write;
        a.illegal_instr = illegal_instr;
        return a;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t vecs[8];
        int   cyc, rw, mw, pw, il, ws;
        bit   done, rwseen;
        int   exp0[5];
        path_t path;
        int   idx;
        logic [6:0] cur_op;
        int   code;

        vecs[0] = '{7'b0000011, 1'b0, 5, 1, 0, 1, 0};
        vecs[1] = '{7'b0100011, 1'b0, 4, 0, 1, 1, 0};
        vecs[2] = '{7'b0110011, 1'b0, 4, 1, 0, 1, 0};
        vecs[3] = '{7'b0010011, 1'b0, 4, 1, 0, 1, 0};
        vecs[4] = '{7'b1100011, 1'b1, 3, 0, 0, 2, 0};
        vecs[5] = '{7'b1100011, 1'b0, 3, 0, 0, 1, 0};
        vecs[6] = '{7'b1101111, 1'b0, 4, 1, 0, 2, 0};
        vecs[7] = '{7'b1111111, 1'b0, 2, 0, 0, 1, 1};

        // Reset values while held
        #3;
        chk("rst_state", state, 0);
        chk("rst_ir_write", ir_write, 0);
        chk("rst_pc_write", pc_write, 0);
        chk("rst_alu_src_b", alu_src_b, 2'b10);
        chk("rst_result_src", result_src, 2'b10);

        // Async reset in the middle of EXECR
        op = 7'b0110011; mem_ready = 1'b1;
        do_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_execr", state, 6);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_reg_write", reg_write, 0);
        chk("mid_rst_pc_write", pc_write, 0);
        chk("mid_rst_ir_write", ir_write, 0);
        chk("mid_rst_alu_src_b", alu_src_b, 2'b10);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ir_write", ir_write, 1);
        chk("post_rst_state", state, 0);

        // Instruction table, mem_ready held high
        op = vecs[0].opc; zero = vecs[0].z; mem_ready = 1'b1;
        do_reset();
        #1;
        for (int r = 0; r < 8; r++) begin
            op = vecs[r].opc; zero = vecs[r].z;
            #1;
            cyc = 0; rw = 0; mw = 0; pw = 0; il = 0; done = 0;
            for (int c = 0; c < 20 && !done; c++) begin
                cyc++;
                rw += int'(reg_write); mw += int'(mem_write);
                pw += int'(pc_write);  il += int'(illegal_instr);
                @(posedge clk); #1;
                if (state == 4'd0) done = 1;
            end
            chk($sformatf("vec%0d_done", r), 32'(done), 1);
            chk($sformatf("vec%0d_cycles", r), cyc, vecs[r].cycles);
            chk($sformatf("vec%0d_reg_write", r), rw, vecs[r].regw);
            chk($sformatf("vec%0d_mem_write", r), mw, vecs[r].memw);
            chk($sformatf("vec%0d_pc_write", r), pw, vecs[r].pcw);
            chk($sformatf("vec%0d_illegal", r), il, vecs[r].ill);
        end

        // sw with two stalled cycles in MEMWRITE
        op = 7'b0100011; zero = 1'b0; mem_ready = 1'b1;
        do_reset();
        rwseen = 0;
        for (int k = 0; k < 3; k++) begin
            #1; rwseen |= reg_write;
            @(posedge clk);
        end
        #1;
        chk("sw_reach_memwrite", state, 5);
        mem_ready = 1'b0;
        ws = 0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) mem_ready = 1'b1;
            #1;
            if (mem_write && adr_src && state == 4'd5) ws++;
            rwseen |= reg_write;
            @(posedge clk); #1;
        end
        chk("sw_stall_mem_write_cycles", ws, 3);
        chk("sw_back_to_fetch", state, 0);
        chk("sw_no_reg_write", 32'(rwseen), 0);

        // WAIT_MEM=0 instance never stalls although mem_ready is low
        exp0 = '{0, 1, 6, 8, 0};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("nowait_state%0d", k), state0, exp0[k]);
            if (k == 0) chk("nowait_ir_write", ir_write0, 1);
            @(posedge clk);
        end

        // Randomized traffic against the path model
        cur_op = 7'b0000011;
        path = path_of(cur_op);
        idx = 0;
        mem_ready = 1'b1;
        op = cur_op;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            op = cur_op;
            mem_ready = ($urandom_range(0, 3) != 0);
            zero = 1'($urandom);
            #1;
            code = path[idx];
            chk("rand_state", state, code);
            chk("rand_outs", 32'(actual_outs()), 32'(expect_outs(code, zero, mem_ready, cur_op)));
            if (!(code inside {0, 3, 5}) || mem_ready) idx++;
            if (idx == path.size()) begin
                case ($urandom_range(0, 6))
                    0: cur_op = 7'b0000011;
                    1: cur_op = 7'b0100011;
                    2: cur_op = 7'b0110011;
                    3: cur_op = 7'b0010011;
                    4: cur_op = 7'b1100011;
                    5: cur_op = 7'b1101111;
                    default: cur_op = 7'($urandom);
                endcase
                path = path_of(cur_op);
                idx = 0;
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
